axis_demux_sched: RTL and testbench

AXIS_DEMUX_SCHED -- requirements
Module: axis_demux_sched

---
 rtl/axis_demux_sched.sv | 120 ++++++++++++
 tb/tb_axis_demux_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_demux_sched.sv
// Command-driven scheduler for an AXI-Stream demux: latches a destination per frame,
// tracks frame progress by snooping the slave-side handshake, and counts completed/dropped frames.
module axis_demux_sched #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_dest,
    input  logic                   cmd_drop,
    input  logic [7:0]             port_en,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   mon_tlast,
    output logic                   enable,
    output logic                   drop,
    output logic [2:0]             sel,
    output logic                   busy,
    input  logic                   cnt_clear,
    output logic [8*CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0]   drop_cnt
);

    // state  | meaning
    // IDLE   | no frame scheduled, ready for a command
    // ARM    | demux enabled, waiting for the frame's first beat
    // ACTIVE | frame in progress, waiting for last
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    logic   beat;
    logic   last;
    logic   done;
    logic   accept;
    logic   drop_next;

    logic [CNT_WIDTH-1:0] frame_q [8];
    logic [CNT_WIDTH-1:0] drop_q;

    assign beat      = mon_tvalid && mon_tready;
    assign last      = beat && mon_tlast;
    // mon_* is only meaningful while the demux is enabled
    assign done      = (state != IDLE) && last;
    assign cmd_ready = (state == IDLE) || done;
    assign accept    = cmd_valid && cmd_ready;
    assign drop_next = cmd_drop || !port_en[cmd_dest];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
            drop   <= 1'b0;
            sel    <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= ARM;
                        enable <= 1'b1;
                        busy   <= 1'b1;
                        sel    <= cmd_dest;
                        drop   <= drop_next;
                    end
                end
                ARM, ACTIVE: begin
                    if (last) begin
                        if (accept) begin
                            state <= ARM;
                            sel   <= cmd_dest;
                            drop  <= drop_next;
                        end else begin
                            state  <= IDLE;
                            enable <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end else if (state == ARM && beat) begin
                        state <= ACTIVE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // Completion is credited to the frame's own sel/drop, still held this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) frame_q[i] <= '0;
            drop_q <= '0;
        end else if (cnt_clear) begin
            for (int i = 0; i < 8; i++) frame_q[i] <= '0;
            drop_q <= '0;
        end else if (done) begin
            if (drop) begin
                if (drop_q != CNT_MAX) drop_q <= drop_q + CNT_ONE;
            end else if (frame_q[sel] != CNT_MAX) begin
                frame_q[sel] <= frame_q[sel] + CNT_ONE;
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_cnt_out
        assign frame_cnt[g*CNT_WIDTH +: CNT_WIDTH] = frame_q[g];
    end
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_axis_demux_sched.sv
// Directed bench for axis_demux_sched: accepted commands go into a scoreboard queue,
// each frame completion pops and checks it and advances a saturating counter model.
module tb_axis_demux_sched;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_dest = 3'd0;
    logic          cmd_drop = 1'b0;
    logic [7:0]    port_en = 8'hFF;
    logic          mon_tvalid = 1'b0;
    logic          mon_tready = 1'b0;
    logic          mon_tlast = 1'b0;
    logic          enable;
    logic          drop;
    logic [2:0]    sel;
    logic          busy;
    logic          cnt_clear = 1'b0;
    logic [8*CW-1:0] frame_cnt;
    logic [CW-1:0] drop_cnt;

    typedef struct packed {
        logic [2:0] dest;
        logic       drop;
    } exp_t;

    exp_t sbq[$];
    int   exp_frame[8];
    int   exp_drop;
    int   errors = 0;
    int   checks = 0;

    axis_demux_sched #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest),
        .cmd_drop(cmd_drop), .port_en(port_en),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .enable(enable), .drop(drop), .sel(sel), .busy(busy),
        .cnt_clear(cnt_clear), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 8; i++) exp_frame[i] = 0;
        exp_drop = 0;
    endtask

    task automatic check_counters(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_frame_cnt%0d", tag, i), 32'(frame_cnt[i*CW +: CW]), exp_frame[i]);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), exp_drop);
    endtask

    task automatic sb_push(input logic [2:0] d, input logic cdrop);
        exp_t e;
        e.dest = d;
        e.drop = cdrop || !port_en[d];
        sbq.push_back(e);
    endtask

    // called in the cycle the DUT sees the frame's last beat
    task automatic sb_complete();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow observed=completion expected=no_completion");
        end else begin
            e = sbq.pop_front();
            chk("done_sel", sel, e.dest);
            chk("done_drop", drop, e.drop);
            if (cnt_clear) model_zero();
            else if (e.drop) exp_drop = (exp_drop == CMAX) ? CMAX : exp_drop + 1;
            else exp_frame[e.dest] = (exp_frame[e.dest] == CMAX) ? CMAX : exp_frame[e.dest] + 1;
        end
    endtask

    task automatic mon_idle();
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] d, input logic cdrop);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dest  = d;
        cmd_drop  = cdrop;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        sb_push(d, cdrop);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("arm_enable", enable, 1);
        chk("arm_busy", busy, 1);
        chk("arm_ready", cmd_ready, 0);
        chk("arm_sel", sel, d);
        chk("arm_drop", drop, sbq[0].drop);
    endtask

    task automatic run_frame(input int nbeats, input int stall_at, input int stall_len,
                             input logic [7:0] en_mid);
        for (int i = 0; i < nbeats; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    mon_tvalid = 1'b1;
                    mon_tready = 1'b0;
                    mon_tlast  = 1'b1;
                    #1;
                    chk("stall_ready", cmd_ready, 0);
                    chk("stall_busy", busy, 1);
                    chk("stall_enable", enable, 1);
                end
            end
            @(negedge clk);
            if (i == 1) port_en = en_mid;
            mon_tvalid = 1'b1;
            mon_tready = 1'b1;
            mon_tlast  = (i == nbeats - 1);
            #1;
            chk("beat_enable", enable, 1);
            if (sbq.size() > 0) begin
                chk("beat_sel", sel, sbq[0].dest);
                chk("beat_drop", drop, sbq[0].drop);
            end
            chk("beat_ready", cmd_ready, (i == nbeats - 1));
            if (i == nbeats - 1) sb_complete();
        end
        @(negedge clk);
        mon_idle();
        #1;
        chk("post_enable", enable, 0);
        chk("post_busy", busy, 0);
        chk("post_ready", cmd_ready, 1);
        check_counters("post");
    endtask

    initial begin
        model_zero();

        // asynchronous reset at start
        #1 rst_n = 1'b0;
        #1;
        chk("rst_enable", enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sel, 0);
        chk("rst_drop", drop, 0);
        check_counters("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", cmd_ready, 1);

        // beats while idle must be ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mon_tvalid = 1'b1;
            mon_tready = 1'b1;
            mon_tlast  = 1'b1;
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_enable", enable, 0);
        end
        @(negedge clk);
        mon_idle();
        #1;
        check_counters("idle");

        // single 4-beat frame to port 5
        port_en = 8'hFF;
        send_cmd(3'd5, 1'b0);
        run_frame(4, -1, 0, 8'hFF);

        // masked port 2; re-enabling mid-frame must not change the decision
        port_en = 8'hFB;
        send_cmd(3'd2, 1'b0);
        run_frame(3, -1, 0, 8'hFF);

        // explicit drop request on an enabled port
        send_cmd(3'd4, 1'b1);
        run_frame(2, -1, 0, 8'hFF);

        // back-to-back single-beat frames 1 then 6
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dest  = 3'd1;
        cmd_drop  = 1'b0;
        #1;
        chk("b2b_ready0", cmd_ready, 1);
        sb_push(3'd1, 1'b0);
        @(negedge clk);
        cmd_dest   = 3'd6;
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b1;
        #1;
        chk("b2b_ready1", cmd_ready, 1);
        chk("b2b_enable1", enable, 1);
        sb_push(3'd6, 1'b0);
        sb_complete();
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("b2b_ready2", cmd_ready, 1);
        chk("b2b_enable2", enable, 1);
        chk("b2b_sel2", sel, 6);
        sb_complete();
        @(negedge clk);
        mon_idle();
        #1;
        chk("b2b_enable_end", enable, 0);
        check_counters("b2b");

        // 3-beat frame stalled 10 cycles after the first beat
        send_cmd(3'd3, 1'b0);
        run_frame(3, 1, 10, 8'hFF);

        // clear, then saturate port 0
        @(negedge clk);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        model_zero();
        #1;
        check_counters("clear");
        for (int f = 0; f < 5; f++) begin
            send_cmd(3'd0, 1'b0);
            run_frame(1, -1, 0, 8'hFF);
        end
        chk("sat_frame0", 32'(frame_cnt[0 +: CW]), 3);

        // clear wins over a simultaneous completion
        send_cmd(3'd0, 1'b0);
        @(negedge clk);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b1;
        cnt_clear  = 1'b1;
        #1;
        sb_complete();
        @(negedge clk);
        cnt_clear = 1'b0;
        mon_idle();
        #1;
        chk("clr_frame0", 32'(frame_cnt[0 +: CW]), 0);
        check_counters("clr");

        // reset in the middle of a 4-beat frame
        send_cmd(3'd7, 1'b0);
        run_frame(1, -1, 0, 8'hFF);
        send_cmd(3'd3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mon_tvalid = 1'b1;
            mon_tready = 1'b1;
            mon_tlast  = 1'b0;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_enable", enable, 0);
        chk("mid_rst_busy", busy, 0);
        model_zero();
        sbq.delete();
        check_counters("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 2; i < 4; i++) begin
            if (i > 2) @(negedge clk);
            mon_tvalid = 1'b1;
            mon_tready = 1'b1;
            mon_tlast  = (i == 3);
            #1;
            chk("post_rst_busy", busy, 0);
            chk("post_rst_enable", enable, 0);
            chk("post_rst_ready", cmd_ready, 1);
        end
        @(negedge clk);
        mon_idle();
        #1;
        chk("post_rst_busy_end", busy, 0);
        check_counters("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
